sdram16_bridge: RTL
===================

// Module: sdram16_bridge
// PURPOSE
//  Converts PicoRV32 32-bit native memory accesses into sequences of 16-bit requests for the SDRAM controller.
//  Sits between the CPU bus decoder (SDRAM region select) and the 16-bit SDRAM controller inside main16.
//  Every access is split into low then high halfword; on writes, a half whose byte strobes are all zero is skipped.
// PARAMETERS
//  SDRAM_ADDRESS_WIDTH         11   row address bits
//  SDRAM_COLUMN_ADDRESS_WIDTH  8    column address bits
//  SDRAM_BANK_BITS             2    bank bits
//  TIMEOUT_CYCLES              1024 watchdog limit per halfword (used only with SDRAM16_BRIDGE_TIMEOUT_EN)
//  HA = SDRAM_BANK_BITS+SDRAM_ADDRESS_WIDTH+SDRAM_COLUMN_ADDRESS_WIDTH (halfword address width, 21 by default)
// PORTS
//  clk          in   1     system clock; all logic is on the rising edge
//  nreset       in   1     asynchronous active-low reset
//  mem_valid    in   1     CPU access request, held until mem_ready
//  mem_addr     in   32    byte address; bits [HA:2] are used
//  mem_wdata    in   32    write data
//  mem_wstrb    in   4     byte strobes; 0 = read
//  mem_ready    out  1     one-cycle completion pulse
//  mem_rdata    out  32    read data, valid while mem_ready=1
//  req_valid    out  1     controller request
//  req_ready    in   1     controller accepts the request on this edge
//  req_addr     out  HA    halfword address {mem_addr[HA:2], half}
//  req_nwr      out  1     1 = read, 0 = write
//  req_wdata    out  16    write halfword
//  req_dqm      out  2     byte mask, active high (= ~strobe pair); 2'b00 on reads
//  rsp_valid    in   1     read data strobe from the controller
//  rsp_data     in   16    read halfword
//  timeout      out  1     sticky watchdog flag (tied to 0 without SDRAM16_BRIDGE_TIMEOUT_EN)
// BEHAVIOUR
//  Reset values: mem_ready=0, mem_rdata=0, req_valid=0, req_addr=0, req_nwr=1, req_wdata=0, req_dqm=0, timeout=0, state=IDLE.
//  States: IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE.
//  - IDLE: on mem_valid, latch addr, wdata, wstrb, and rd=(wstrb==0).
//    - Read, or write with wstrb[1:0]!=0 -> LO_REQ.
//    - Write with only wstrb[3:2]!=0 -> HI_REQ.
//  - x_REQ: req_valid=1; address, data and dqm stay stable until req_ready=1 at an edge.
//    - On that edge, a read goes to x_WAIT.
//    - A write from LO_REQ goes to HI_REQ if wstrb[3:2]!=0, otherwise to DONE; a write from HI_REQ goes to DONE.
//    - req_valid drops in the cycle after acceptance.
//  - x_WAIT: on rsp_valid, capture rsp_data into mem_rdata[15:0] (LO) or [31:16] (HI).
//    - LO_WAIT -> HI_REQ; HI_WAIT -> DONE.
//  - DONE: mem_ready=1 for exactly one cycle, then IDLE.
//    - IDLE does not resample mem_valid in the cycle mem_ready is high.
//  Halfword order: low half is at even halfword address {a,0}; high half at {a,1} (little-endian).
//  Latency with a zero-wait controller: write32 = 4 cycles from mem_valid to mem_ready; read32 adds the controller read latency for each half.
//  - rsp_valid outside x_WAIT is ignored.
//  - req_ready while req_valid=0 is ignored.
//  - mem_wdata and mem_wstrb changes after IDLE are ignored (latched copies are used).
//  - Address bits above HA are ignored (wrap).
//  - Write with wstrb==4'b0000 is impossible: zero strobes mean read.
//  - nreset low at any time aborts immediately to reset values; a partially written word stays partially written.
// CONFIGURATION
//  SDRAM16_BRIDGE_TIMEOUT_EN defined:
//    - A 16-bit counter is cleared when entering any x_REQ or x_WAIT state and increments while in that state.
//    - On reaching TIMEOUT_CYCLES: drop req_valid, set timeout=1 (sticky until reset), go to DONE with mem_rdata=32'hFFFF_FFFF so the CPU cannot hang.
//  Not defined: no counter, timeout tied to 0, the bridge waits indefinitely.
// TESTING
//  1 Read addr 0x0000_0010, controller returns 16'h5678 then 16'h1234 -> req_addr 8 then 9, req_nwr=1, mem_rdata=32'h1234_5678 with one mem_ready pulse.
//  2 Write 0xCAFEBABE, wstrb 4'hF, addr 0x20 -> two requests: addr 16 data BABE dqm 00, then addr 17 data CAFE dqm 00; mem_ready 4 cycles after mem_valid when req_ready=1.
//  3 Byte write wstrb 4'b0100, addr 0x24 -> single request addr 19 dqm 2'b10; no low-half request.
//  4 req_ready held low 5 cycles -> req_valid, req_addr, req_wdata and req_dqm stable throughout; stray rsp_valid in IDLE leaves mem_rdata unchanged.
//  5 nreset asserted while in LO_WAIT -> next cycle req_valid=0 and mem_ready=0; a new read after release completes normally.
//  6 (TIMEOUT_EN, TIMEOUT_CYCLES=16) req_ready never asserted -> mem_ready after 16 cycles, mem_rdata=FFFF_FFFF, timeout=1.

Source files
------------

// File: rtl/sdram16_bridge.sv
// sdram16_bridge: splits 32-bit PicoRV32 accesses into low/high 16-bit SDRAM requests; SDRAM16_BRIDGE_TIMEOUT_EN adds a per-halfword watchdog
module sdram16_bridge #(
  parameter int SDRAM_ADDRESS_WIDTH = 11,
  parameter int SDRAM_COLUMN_ADDRESS_WIDTH = 8,
  parameter int SDRAM_BANK_BITS = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int HA = SDRAM_BANK_BITS + SDRAM_ADDRESS_WIDTH + SDRAM_COLUMN_ADDRESS_WIDTH
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          mem_valid,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wstrb,
  output logic          mem_ready,
  output logic [31:0]   mem_rdata,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [HA-1:0] req_addr,
  output logic          req_nwr,
  output logic [15:0]   req_wdata,
  output logic [1:0]    req_dqm,
  input  logic          rsp_valid,
  input  logic [15:0]   rsp_data,
  output logic          timeout
);
  localparam logic [2:0] IDLE = 3'd0, LO_REQ = 3'd1, LO_WAIT = 3'd2, HI_REQ = 3'd3, HI_WAIT = 3'd4, DONE = 3'd5;
  logic [2:0] state_q, state_d;
  logic [HA-2:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d, mem_rdata_q, mem_rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic rd_q, rd_d, mem_ready_q, mem_ready_d, req_valid_q, req_valid_d, req_nwr_q, req_nwr_d;
  logic [HA-1:0] req_addr_q, req_addr_d;
  logic [15:0] req_wdata_q, req_wdata_d;
  logic [1:0] req_dqm_q, req_dqm_d;
  logic go_lo, go_hi;
  logic unused_ok;
  assign unused_ok = ^{mem_addr[31:HA+1], mem_addr[1:0], TIMEOUT_CYCLES[0]};
`ifdef SDRAM16_BRIDGE_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  logic busy;
  assign busy = state_q inside {LO_REQ, LO_WAIT, HI_REQ, HI_WAIT};
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rd_d = rd_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    req_valid_d = req_valid_q;
    req_addr_d = req_addr_q;
    req_nwr_d = req_nwr_q;
    req_wdata_d = req_wdata_q;
    req_dqm_d = req_dqm_q;
    go_lo = 1'b0;
    go_hi = 1'b0;
    case (state_q)
      IDLE: if (mem_valid && !mem_ready_q) begin
        base_d = mem_addr[HA:2];
        wdata_d = mem_wdata;
        wstrb_d = mem_wstrb;
        rd_d = mem_wstrb == 4'b0000;
        go_lo = rd_d || |mem_wstrb[1:0];
        go_hi = !go_lo;
      end
      LO_REQ, HI_REQ: if (req_ready) begin
        req_valid_d = 1'b0;
        state_d = rd_q ? (state_q == LO_REQ ? LO_WAIT : HI_WAIT) : DONE;
        go_hi = !rd_q && state_q == LO_REQ && |wstrb_q[3:2];
      end
      LO_WAIT: if (rsp_valid) begin
        mem_rdata_d[15:0] = rsp_data;
        go_hi = 1'b1;
      end
      HI_WAIT: if (rsp_valid) begin
        mem_rdata_d[31:16] = rsp_data;
        state_d = DONE;
      end
      DONE: begin
        mem_ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Launch the next halfword request from the latched (or just-latching) access
    if (go_lo || go_hi) begin
      state_d = go_lo ? LO_REQ : HI_REQ;
      req_valid_d = 1'b1;
      req_addr_d = {base_d, go_hi};
      req_nwr_d = rd_d;
      req_wdata_d = go_hi ? wdata_d[31:16] : wdata_d[15:0];
      req_dqm_d = rd_d ? 2'b00 : ~(go_hi ? wstrb_d[3:2] : wstrb_d[1:0]);
    end
`ifdef SDRAM16_BRIDGE_TIMEOUT_EN
    timeout_d = timeout_q;
    cnt_d = cnt_q + 16'd1;
    if (busy && cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
      state_d = DONE;
      req_valid_d = 1'b0;
      timeout_d = 1'b1;
      mem_rdata_d = '1;
    end
    if (state_d != state_q) cnt_d = '0;
`endif
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      base_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rd_q <= 1'b1;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      req_valid_q <= 1'b0;
      req_addr_q <= '0;
      req_nwr_q <= 1'b1;
      req_wdata_q <= '0;
      req_dqm_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rd_q <= rd_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      req_valid_q <= req_valid_d;
      req_addr_q <= req_addr_d;
      req_nwr_q <= req_nwr_d;
      req_wdata_q <= req_wdata_d;
      req_dqm_q <= req_dqm_d;
    end
  end
`ifdef SDRAM16_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign req_valid = req_valid_q;
  assign req_addr = req_addr_q;
  assign req_nwr = req_nwr_q;
  assign req_wdata = req_wdata_q;
  assign req_dqm = req_dqm_q;
endmodule
